// File: rtl/risky_mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit, one transaction in flight.
// Optional performance counters are built when RISKY_ARB_PERF_EN is defined.
module risky_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  input  logic                lsu_req_valid,
  input  logic                lsu_req_we,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_be,
  output logic                lsu_req_ready,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_be,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                busy
`ifdef RISKY_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_lsu_grants,
  output logic [31:0]         perf_if_stall
`endif
);

  localparam int unsigned STREAK_W = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                owner_lsu;
  logic                if_win;
  logic                lsu_win;
  logic                rsp_fire;

  // IF wins only when LSU is idle or the LSU streak has hit its limit.
  assign if_win  = !rst && (state == IDLE) && if_req_valid &&
                   (!lsu_req_valid || (streak == STREAK_MAX));
  assign lsu_win = !rst && (state == IDLE) && lsu_req_valid && !if_win;

  assign if_req_ready  = if_win;
  assign lsu_req_ready = lsu_win;

  // Responses outside WAIT are spurious and never reach a requester.
  assign rsp_fire      = (state == WAIT) && mem_rsp_valid;
  assign if_rsp_valid  = rsp_fire && !owner_lsu;
  assign lsu_rsp_valid = rsp_fire && owner_lsu;
  assign if_rsp_rdata  = if_rsp_valid ? mem_rsp_rdata : '0;
  assign lsu_rsp_rdata = (lsu_rsp_valid && !mem_req_we) ? mem_rsp_rdata : '0;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      streak        <= '0;
      owner_lsu     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!if_req_valid) begin
            streak <= '0;
          end
          if (if_win) begin
            streak        <= '0;
            owner_lsu     <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= if_req_addr;
            mem_req_wdata <= '0;
            mem_req_be    <= '1;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end else if (lsu_win) begin
            if (if_req_valid && (streak != STREAK_MAX)) begin
              streak <= streak + STREAK_W'(1);
            end
            owner_lsu     <= 1'b1;
            mem_req_we    <= lsu_req_we;
            mem_req_addr  <= lsu_req_addr;
            mem_req_wdata <= lsu_req_wdata;
            mem_req_be    <= lsu_req_be;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RISKY_ARB_PERF_EN
  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_grants  <= '0;
      perf_lsu_grants <= '0;
      perf_if_stall   <= '0;
    end else begin
      if (if_win) perf_if_grants <= perf_if_grants + 32'(1);
      if (lsu_win) perf_lsu_grants <= perf_lsu_grants + 32'(1);
      if (if_req_valid && !if_req_ready) perf_if_stall <= perf_if_stall + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_risky_mem_arbiter.sv
// Directed bench for risky_mem_arbiter with a small latency-programmable memory model.
// Define RISKY_ARB_PERF_EN to also cover the performance counters.
module tb_risky_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_we;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_be;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        busy;
`ifdef RISKY_ARB_PERF_EN
  logic [31:0] perf_if_grants;
  logic [31:0] perf_lsu_grants;
  logic [31:0] perf_if_stall;
`endif

  int n_checks;
  int n_fail;

  risky_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LSU_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_be(lsu_req_be), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .busy(busy)
`ifdef RISKY_ARB_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_lsu_grants(perf_lsu_grants),
    .perf_if_stall(perf_if_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: responds lat cycles after accepting a request; spur_rsp injects stray responses.
  int          lat;
  int          cnt;
  bit          pending;
  bit          model_rsp;
  bit          spur_rsp;
  logic        acc_q;
  logic [31:0] model_rdata;
  logic [31:0] rsp_data;
  logic [31:0] spur_rdata;

  assign mem_rsp_valid = model_rsp | spur_rsp;
  assign mem_rsp_rdata = model_rsp ? model_rdata : spur_rdata;

  always @(posedge clk) begin
    if (rst) acc_q <= 1'b0;
    else     acc_q <= mem_req_valid && mem_req_ready;
  end

  always @(negedge clk) begin
    model_rsp = 1'b0;
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (acc_q === 1'b1) begin
        pending = 1'b1;
        cnt     = lat;
      end
      if (pending) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          model_rsp   = 1'b1;
          model_rdata = rsp_data;
          pending     = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_req_valid  = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (2) step();
    #1;
    n_checks++;
    if ({busy, mem_req_valid, if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {busy, mem_req_valid, if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid});
    end
    n_checks++;
    if ({mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be} !== 69'b0) begin
      n_fail++;
      $display("FAIL reset_fields: got we=%b addr=%h wdata=%h be=%b required all 0",
               mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be);
    end
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
    rst = 1'b0;
    step();
`ifdef RISKY_ARB_PERF_EN
    n_checks++;
    if ({perf_if_grants, perf_lsu_grants, perf_if_stall} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d %0d %0d required 0 0 0",
               perf_if_grants, perf_lsu_grants, perf_if_stall);
    end
`endif
  endtask

  task automatic test_arbitration();
    bit [9:0] seq;
    bit [9:0] exp_seq;
    int       g;
    int       b;
    int       dbl;
    exp_seq = 10'b0111101111;
    seq = '0;
    g = 0;
    b = 0;
    dbl = 0;
    lat = 1;
    rsp_data = 32'h0000_1111;
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h0000_0300;
    lsu_req_valid = 1'b1;
    lsu_req_we    = 1'b0;
    lsu_req_addr  = 32'h0000_0400;
    lsu_req_be    = 4'hF;
    while (g < 10 && b < 100) begin
      #1;
      if (if_req_ready || lsu_req_ready) begin
        if (if_req_ready && lsu_req_ready) dbl++;
        seq[g] = lsu_req_ready;
        g++;
      end
      step();
      b++;
    end
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
    n_checks++;
    if (g != 10) begin
      n_fail++;
      $display("FAIL arb_grant_count: got %0d grants required 10", g);
    end
    n_checks++;
    if (seq !== exp_seq) begin
      n_fail++;
      $display("FAIL arb_order: got %b required %b (bit0 first, 1=LSU)", seq, exp_seq);
    end
    n_checks++;
    if (dbl != 0) begin
      n_fail++;
      $display("FAIL arb_one_ready: got %0d double grants required 0", dbl);
    end
    b = 0;
    while (busy && b < 20) begin
      step();
      b++;
    end
`ifdef RISKY_ARB_PERF_EN
    n_checks++;
    if (perf_lsu_grants !== 32'd8 || perf_if_grants !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_grants: got lsu=%0d if=%0d required 8 2", perf_lsu_grants, perf_if_grants);
    end
    n_checks++;
    if (perf_if_stall !== 32'd26) begin
      n_fail++;
      $display("FAIL perf_stall: got %0d required 26", perf_if_stall);
    end
`endif
  endtask

  task automatic test_if_read();
    int pulses;
    int lsu_pulses;
    int at_k;
    logic [31:0] data;
    pulses = 0;
    lsu_pulses = 0;
    at_k = 0;
    data = '0;
    lat = 3;
    rsp_data = 32'hDEAD_BEEF;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0100;
    #1;
    n_checks++;
    if (if_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL if_accept: got if_ready=%b lsu_ready=%b required 1 0", if_req_ready, lsu_req_ready);
    end
    step();
    if_req_valid = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_we !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL if_req: got valid=%b addr=%h we=%b busy=%b required 1 100 0 1",
               mem_req_valid, mem_req_addr, mem_req_we, busy);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (mem_req_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL if_req_drop: got mem_req_valid=%b required 0 after accept", mem_req_valid);
        end
      end
      if (if_rsp_valid) begin
        pulses++;
        at_k = k;
        data = if_rsp_rdata;
      end
      if (lsu_rsp_valid) lsu_pulses++;
    end
    n_checks++;
    if (pulses != 1 || at_k != 3 || data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL if_rsp: got pulses=%0d at=%0d data=%h required 1 3 deadbeef", pulses, at_k, data);
    end
    n_checks++;
    if (lsu_pulses != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL if_rsp_other: got lsu_pulses=%0d busy=%b required 0 0", lsu_pulses, busy);
    end
  endtask

  task automatic test_lsu_write();
    int pulses;
    int if_pulses;
    logic [31:0] data;
    pulses = 0;
    if_pulses = 0;
    data = 32'hFFFF_FFFF;
    lat = 1;
    rsp_data = 32'hFFFF_FFFF;
    lsu_req_valid = 1'b1;
    lsu_req_we    = 1'b1;
    lsu_req_addr  = 32'h0000_0200;
    lsu_req_wdata = 32'h1234_5678;
    lsu_req_be    = 4'b0011;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_accept: got lsu_ready=%b if_ready=%b required 1 0", lsu_req_ready, if_req_ready);
    end
    step();
    lsu_req_valid = 1'b0;
    n_checks++;
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be} !==
        {1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'b0011}) begin
      n_fail++;
      $display("FAIL wr_fields: got v=%b we=%b addr=%h wdata=%h be=%b required 1 1 200 12345678 0011",
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      if (lsu_rsp_valid) begin
        pulses++;
        data = lsu_rsp_rdata;
      end
      if (if_rsp_valid) if_pulses++;
    end
    n_checks++;
    if (pulses != 1 || data !== 32'h0 || if_pulses != 0) begin
      n_fail++;
      $display("FAIL wr_ack: got pulses=%0d rdata=%h if_pulses=%0d required 1 0 0", pulses, data, if_pulses);
    end
    lsu_req_we = 1'b0;
  endtask

  task automatic test_both_valid();
    int b;
    int bad;
    b = 0;
    bad = 0;
    lat = 1;
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h0000_0140;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h0000_0240;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL both_prio: got lsu_ready=%b if_ready=%b required 1 0", lsu_req_ready, if_req_ready);
    end
    step();
    lsu_req_valid = 1'b0;
    while (busy && b < 20) begin
      if (if_req_ready || lsu_req_ready) bad++;
      step();
      b++;
    end
    #1;
    n_checks++;
    if (busy !== 1'b0 || bad != 0 || if_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL both_if_next: got busy=%b ready_in_busy=%0d if_ready=%b required 0 0 1",
               busy, bad, if_req_ready);
    end
    step();
    if_req_valid = 1'b0;
    b = 0;
    while (busy && b < 20) begin
      step();
      b++;
    end
  endtask

  task automatic test_stall_spurious();
    int pulses;
    int bad;
    logic [31:0] data;
    pulses = 0;
    bad = 0;
    data = '0;
    spur_rsp   = 1'b1;
    spur_rdata = 32'h5555_AAAA;
    #1;
    n_checks++;
    if (if_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_idle: got if_rsp=%b lsu_rsp=%b busy=%b required 0 0 0",
               if_rsp_valid, lsu_rsp_valid, busy);
    end
    step();
    spur_rsp = 1'b0;
    mem_req_ready = 1'b0;
    lat = 2;
    rsp_data = 32'hCAFE_F00D;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0180;
    #1;
    n_checks++;
    if (if_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_accept: got if_ready=%b required 1", if_req_ready);
    end
    step();
    if_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      spur_rsp = (k == 2);
      #1;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h180 || mem_req_we !== 1'b0) bad++;
      if (if_rsp_valid || lsu_rsp_valid || if_req_ready || lsu_req_ready) pulses++;
      step();
    end
    spur_rsp = 1'b0;
    n_checks++;
    if (bad != 0 || pulses != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_req: got unstable=%0d stray=%0d busy=%b required 0 0 1", bad, pulses, busy);
    end
    mem_req_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (if_rsp_valid) begin
        pulses++;
        data = if_rsp_rdata;
      end
    end
    n_checks++;
    if (pulses != 1 || data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL stall_rsp: got pulses=%0d data=%h required 1 cafef00d", pulses, data);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [31:0] data;
    pulses = 0;
    data = '0;
    lat = 5;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_01C0;
    step();
    if_req_valid = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_wait: got busy=%b mem_req_valid=%b required 1 0", busy, mem_req_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
         if_rsp_valid, lsu_rsp_valid, if_req_ready, lsu_req_ready} !== 75'b0) begin
      n_fail++;
      $display("FAIL rmid_clear: got busy=%b v=%b addr=%h be=%b rsp=%b%b required all 0",
               busy, mem_req_valid, mem_req_addr, mem_req_be, if_rsp_valid, lsu_rsp_valid);
    end
    step();
    step();
    rst = 1'b0;
    spur_rsp   = 1'b1;
    spur_rdata = 32'h7777_7777;
    #1;
    n_checks++;
    if (if_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_late_rsp: got if_rsp=%b lsu_rsp=%b required 0 0", if_rsp_valid, lsu_rsp_valid);
    end
    step();
    spur_rsp = 1'b0;
    lat = 2;
    rsp_data = 32'h1357_9BDF;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_01C4;
    #1;
    n_checks++;
    if (if_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_reissue: got if_ready=%b required 1", if_req_ready);
    end
    step();
    if_req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (if_rsp_valid) begin
        pulses++;
        data = if_rsp_rdata;
      end
    end
    n_checks++;
    if (pulses != 1 || data !== 32'h1357_9BDF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_rsp: got pulses=%0d data=%h busy=%b required 1 13579bdf 0", pulses, data, busy);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    if_req_valid  = 1'b0;
    if_req_addr   = '0;
    lsu_req_valid = 1'b0;
    lsu_req_we    = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wdata = '0;
    lsu_req_be    = '0;
    mem_req_ready = 1'b1;
    lat           = 1;
    rsp_data      = '0;
    spur_rsp      = 1'b0;
    spur_rdata    = '0;
    test_reset();
    test_arbitration();
    test_if_read();
    test_lsu_write();
    test_both_valid();
    test_stall_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
